// File: rtl/tof_avg_acc.sv
// Averages 2**N_LOG2 in-window TDC hits per frame and re-arms the TDC after every hit or timeout.
// Latency: last hit edge -> m_valid in REARM_CYC+1 cycles; a result is held in OUT until m_ready (never dropped).
module tof_avg_acc #(
   parameter int TOF_W       = 13,
   parameter int N_LOG2      = 3,
   parameter int TOF_MIN     = 1,
   parameter int TOF_MAX     = 8000,
   parameter int TIMEOUT_CYC = 1024,
   parameter int REARM_CYC   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [TOF_W-1:0] tof_in,
   input  logic             tof_valid,
   output logic             tdc_rst_n,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [TOF_W-1:0] avg_out,
   output logic [7:0]       miss_cnt,
   output logic [7:0]       rej_cnt
);

   localparam int ACC_W = TOF_W + N_LOG2;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int RC_W  = $clog2(REARM_CYC + 1);
   localparam logic [N_LOG2:0]  HIT_FULL   = {1'b1, {N_LOG2{1'b0}}};
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [RC_W-1:0]  RC_LAST    = RC_W'(REARM_CYC - 1);
   localparam logic [TOF_W-1:0] WIN_LO     = TOF_W'(TOF_MIN);
   localparam logic [TOF_W-1:0] WIN_HI     = TOF_W'(TOF_MAX);

   typedef enum logic [1:0] {IDLE, ARM, REARM, OUT} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [N_LOG2:0]    hit_q, hit_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [RC_W-1:0]    rc_q, rc_d;
   logic [7:0]         miss_q, miss_d;
   logic [7:0]         rej_q, rej_d;
   logic [TOF_W-1:0]   avg_q, avg_d;
   logic               vld_dly_q, vld_dly_d;
   logic               hit, in_win, timeout, clr;

   // A sticky out_valid from before the re-arm must first be seen low in ARM to produce an edge.
   assign hit     = (state_q == ARM) && tof_valid && !vld_dly_q;
   assign in_win  = (tof_in >= WIN_LO) && (tof_in <= WIN_HI);
   assign timeout = (tmr_q == TMR_LAST);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      hit_d     = hit_q;
      tmr_d     = tmr_q;
      rc_d      = rc_q;
      miss_d    = miss_q;
      rej_d     = rej_q;
      avg_d     = avg_q;
      clr       = 1'b0;
      vld_dly_d = (state_q == ARM) ? tof_valid : 1'b1;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               state_d = ARM;
               tmr_d   = '0;
            end
         end
         ARM: begin
            if (!en) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
               if (hit) begin
                  state_d = REARM;
                  rc_d    = '0;
                  if (in_win) begin
                     acc_d = acc_q + ACC_W'(tof_in);
                     hit_d = hit_q + (N_LOG2 + 1)'(1);
                  end else if (rej_q != 8'hFF) begin
                     rej_d = rej_q + 8'd1;
                  end
               end else if (timeout) begin
                  state_d = REARM;
                  rc_d    = '0;
                  if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
               end
            end
         end
         REARM: begin
            if (!en) begin
               state_d = IDLE;
               clr     = 1'b1;
            end else if (rc_q == RC_LAST) begin
               if (hit_q == HIT_FULL) begin
                  state_d = OUT;
                  avg_d   = acc_q[ACC_W-1:N_LOG2];
               end else begin
                  state_d = ARM;
                  tmr_d   = '0;
               end
            end else begin
               rc_d = rc_q + RC_W'(1);
            end
         end
         OUT: begin
            // en is only looked at once the result has been taken.
            if (m_ready) begin
               clr     = 1'b1;
               tmr_d   = '0;
               state_d = en ? ARM : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (clr) begin
         acc_d  = '0;
         hit_d  = '0;
         miss_d = '0;
         rej_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         hit_q     <= '0;
         tmr_q     <= '0;
         rc_q      <= '0;
         miss_q    <= '0;
         rej_q     <= '0;
         avg_q     <= '0;
         vld_dly_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         hit_q     <= hit_d;
         tmr_q     <= tmr_d;
         rc_q      <= rc_d;
         miss_q    <= miss_d;
         rej_q     <= rej_d;
         avg_q     <= avg_d;
         vld_dly_q <= vld_dly_d;
      end
   end

   assign tdc_rst_n = (state_q == ARM);
   assign m_valid   = (state_q == OUT);
   assign avg_out   = avg_q;
   assign miss_cnt  = miss_q;
   assign rej_cnt   = rej_q;

endmodule

// File: tb/tb_tof_avg_acc.sv
// Bench for tof_avg_acc: emulates the TDC handshake per attempt and checks each frame result.
module tb_tof_avg_acc;
   localparam int TOF_W       = 13;
   localparam int N_LOG2      = 3;
   localparam int TOF_MIN     = 1;
   localparam int TOF_MAX     = 8000;
   localparam int TIMEOUT_CYC = 1024;
   localparam int REARM_CYC   = 2;

   logic             clk = 1'b0;
   logic             rst, en, tof_valid, m_ready;
   logic [TOF_W-1:0] tof_in;
   logic             tdc_rst_n, m_valid;
   logic [TOF_W-1:0] avg_out;
   logic [7:0]       miss_cnt, rej_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Attempt kinds: 0 = hit, 1 = let it time out, 2 = hit on the very last timer cycle.
   int q_kind[$];
   int q_tof[$];

   typedef struct packed {
      logic [3:0]        n;
      logic [9:0][12:0]  tof;
      logic [12:0]       exp_avg;
      logic [7:0]        exp_rej;
   } vec_t;
   vec_t vt[5];

   tof_avg_acc #(
      .TOF_W(TOF_W), .N_LOG2(N_LOG2), .TOF_MIN(TOF_MIN), .TOF_MAX(TOF_MAX),
      .TIMEOUT_CYC(TIMEOUT_CYC), .REARM_CYC(REARM_CYC)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .tof_in(tof_in), .tof_valid(tof_valid),
      .tdc_rst_n(tdc_rst_n), .m_valid(m_valid), .m_ready(m_ready),
      .avg_out(avg_out), .miss_cnt(miss_cnt), .rej_cnt(rej_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Waits (checking the current negedge first) until tdc_rst_n (which=0) or m_valid (which=1) equals lvl.
   task automatic wait_sig(input int which, input logic lvl, input int bound, input string nm);
      bit got = 0;
      for (int i = 0; i <= bound; i++) begin
         if (((which == 0) ? tdc_rst_n : m_valid) === lvl) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s: got no level %0d within %0d cycles, expected it", nm, lvl, bound);
      end
   endtask

   task automatic attempt(input int kind, input int tof, input int dly);
      wait_sig(0, 1'b1, 3000, "wait_arm");
      if (kind == 1) begin
         wait_sig(0, 1'b0, TIMEOUT_CYC + 20, "wait_timeout");
      end else begin
         repeat ((kind == 2) ? TIMEOUT_CYC - 1 : dly) @(negedge clk);
         tof_in    = TOF_W'(tof);
         tof_valid = 1'b1;
         wait_sig(0, 1'b0, TIMEOUT_CYC + 20, "wait_rearm");
         tof_valid = 1'b0;
      end
   endtask

   task automatic play_q();
      for (int i = 0; i < q_kind.size(); i++)
         attempt(q_kind[i], q_tof[i], $urandom_range(1, 12));
   endtask

   task automatic clear_q();
      q_kind.delete();
      q_tof.delete();
   endtask

   task automatic push(input int kind, input int tof);
      q_kind.push_back(kind);
      q_tof.push_back(tof);
   endtask

   // Frame outcome straight from the rules: accepted values averaged, rejects and misses counted.
   task automatic model_frame(output int ea, output int em, output int er);
      int sum = 0;
      em = 0;
      er = 0;
      for (int i = 0; i < q_kind.size(); i++) begin
         if (q_kind[i] == 1) em = (em < 255) ? em + 1 : 255;
         else if (q_tof[i] >= TOF_MIN && q_tof[i] <= TOF_MAX) sum += q_tof[i];
         else er = (er < 255) ? er + 1 : 255;
      end
      ea = sum / (1 << N_LOG2);
   endtask

   task automatic expect_frame(input string nm, input int ea, input int em, input int er);
      wait_sig(1, 1'b1, 20, {nm, "_mvalid"});
      chk({nm, "_avg"}, 32'(avg_out), ea);
      chk({nm, "_miss"}, 32'(miss_cnt), em);
      chk({nm, "_rej"}, 32'(rej_cnt), er);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk({nm, "_mvalid_drop"}, 32'(m_valid), 0);
   endtask

   initial begin
      int ea, em, er, acc, cnt, bad, lat, r;

      rst = 1'b1; en = 1'b0; tof_valid = 1'b0; tof_in = '0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tdc_rst_n", 32'(tdc_rst_n), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_avg", 32'(avg_out), 0);
      chk("rst_miss", 32'(miss_cnt), 0);
      chk("rst_rej", 32'(rej_cnt), 0);
      rst = 1'b0;
      en  = 1'b1;

      // Table-driven frames with hand-computed results.
      for (int v = 0; v < 5; v++) vt[v] = '0;
      vt[0].n = 8;  for (int i = 0; i < 8; i++)  vt[0].tof[i] = 13'(100 + i);
      vt[0].exp_avg = 103; vt[0].exp_rej = 0;
      vt[1].n = 10; for (int i = 0; i < 10; i++) vt[1].tof[i] = 13'd500;
      vt[1].tof[1] = 13'd0; vt[1].tof[4] = 13'd8100;
      vt[1].exp_avg = 500; vt[1].exp_rej = 2;
      vt[2].n = 8;  for (int i = 0; i < 8; i++)  vt[2].tof[i] = 13'(1 + i);
      vt[2].exp_avg = 4;   vt[2].exp_rej = 0;
      vt[3].n = 8;  for (int i = 0; i < 8; i++)  vt[3].tof[i] = 13'd8000;
      vt[3].exp_avg = 8000; vt[3].exp_rej = 0;
      vt[4].n = 10; for (int i = 0; i < 10; i++) vt[4].tof[i] = 13'd1;
      vt[4].tof[0] = 13'd8001; vt[4].tof[5] = 13'd0;
      vt[4].exp_avg = 1;   vt[4].exp_rej = 2;
      for (int v = 0; v < 5; v++) begin
         clear_q();
         for (int i = 0; i < int'(vt[v].n); i++) push(0, int'(vt[v].tof[i]));
         play_q();
         expect_frame($sformatf("vec%0d", v), int'(vt[v].exp_avg), 0, int'(vt[v].exp_rej));
      end

      // Hit on the same cycle as the timeout: the hit wins.
      clear_q();
      push(2, 200);
      for (int i = 0; i < 7; i++) push(0, 200);
      play_q();
      expect_frame("hit_vs_timeout", 200, 0, 0);

      // Pure timeout: ARM length, miss count and re-arm pulse width.
      wait_sig(0, 1'b1, 3000, "to_arm");
      cnt = 1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tdc_rst_n) cnt++;
         else break;
      end
      chk("timeout_arm_cycles", cnt, TIMEOUT_CYC);
      chk("timeout_miss", 32'(miss_cnt), 1);
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!tdc_rst_n) cnt++;
         else break;
      end
      chk("rearm_low_cycles", cnt, REARM_CYC);
      chk("back_in_arm", 32'(tdc_rst_n), 1);
      clear_q();
      for (int i = 0; i < 8; i++) push(0, 10);
      play_q();
      expect_frame("after_timeout", 10, 1, 0);

      // out_valid held high across the re-arm is not a new hit.
      wait_sig(0, 1'b1, 3000, "sticky_arm");
      repeat (2) @(negedge clk);
      tof_in = 13'd300; tof_valid = 1'b1;
      wait_sig(0, 1'b0, TIMEOUT_CYC + 20, "sticky_rearm");
      wait_sig(0, 1'b1, 20, "sticky_rearm_end");
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tdc_rst_n !== 1'b1) bad++;
      end
      chk("sticky_no_hit", bad, 0);
      tof_valid = 1'b0;
      clear_q();
      for (int i = 0; i < 7; i++) push(0, 100);
      play_q();
      expect_frame("sticky", 125, 0, 0);

      // Abort after three accepted hits and a reject; the next frame starts clean.
      clear_q();
      push(0, 1000); push(0, 1000); push(0, 0); push(0, 1000);
      play_q();
      wait_sig(0, 1'b1, 20, "abort_arm");
      en = 1'b0;
      @(negedge clk);
      chk("abort_tdc_rst_n", 32'(tdc_rst_n), 0);
      chk("abort_rej_clr", 32'(rej_cnt), 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid !== 1'b0 || tdc_rst_n !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("abort_stays_idle", bad, 0);
      en = 1'b1;
      clear_q();
      for (int i = 0; i < 8; i++) push(0, 50);
      play_q();
      expect_frame("after_abort", 50, 0, 0);

      // Reject counter saturates.
      clear_q();
      for (int i = 0; i < 260; i++) push(0, (i % 2) ? 0 : 8191);
      for (int i = 0; i < 8; i++) push(0, 4000);
      play_q();
      expect_frame("rej_sat", 4000, 0, 255);

      // Reset in the middle of a frame.
      clear_q();
      push(0, 3000); push(0, 0);
      play_q();
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tdc_rst_n", 32'(tdc_rst_n), 0);
      chk("midrst_avg", 32'(avg_out), 0);
      chk("midrst_rej", 32'(rej_cnt), 0);
      rst = 1'b0;
      clear_q();
      for (int i = 0; i < 8; i++) push(0, 77);
      play_q();
      expect_frame("after_midrst", 77, 0, 0);

      // Random frames against the reference model.
      for (int f = 0; f < 6; f++) begin
         clear_q();
         acc = 0;
         while (acc < (1 << N_LOG2)) begin
            r = $urandom_range(0, 9);
            if (r == 0) push(1, 0);
            else if (r == 1) push(0, $urandom_range(0, 1) ? 0 : $urandom_range(8001, 8191));
            else begin
               push(0, $urandom_range(TOF_MIN, TOF_MAX));
               acc++;
            end
         end
         model_frame(ea, em, er);
         play_q();
         expect_frame($sformatf("rnd%0d", f), ea, em, er);
      end

      // Latency, backpressure with en dropped during OUT, then IDLE after the handshake.
      clear_q();
      for (int i = 0; i < 7; i++) push(0, 2000);
      play_q();
      wait_sig(0, 1'b1, 3000, "lat_arm");
      repeat (2) @(negedge clk);
      tof_in = 13'd2000; tof_valid = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (!tdc_rst_n) tof_valid = 1'b0;
         if (m_valid) begin
            lat = i;
            break;
         end
      end
      chk("hit_to_mvalid_latency", lat, REARM_CYC + 1);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 5) en = 1'b0;
         if (m_valid !== 1'b1 || avg_out !== 13'd2000 || miss_cnt !== 8'd0 ||
             rej_cnt !== 8'd0 || tdc_rst_n !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("out_hold", bad, 0);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("bp_mvalid_drop", 32'(m_valid), 0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (tdc_rst_n !== 1'b0 || m_valid !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("idle_after_hs", bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
